// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the resampler chain: default FIFO depth and rounding-mode encoding.
package dsp_pkg;

    localparam int RESAMP_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ROUND_TRUNC     = 2'd0,
        ROUND_HALF_UP   = 2'd1,
        ROUND_HALF_EVEN = 2'd2,
        ROUND_SAT       = 2'd3
    } round_type_e;

    // Width needed to hold a fill level of 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word fall-through FIFO: the head entry is visible on rdata_o
// the cycle after it is written. DEPTH must be a power of two.
module sync_fifo_fwft
    import dsp_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = RESAMP_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = level_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: storage has no reset; the pointers and level alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + AW'(1);
            if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_i, pop_i})
                2'b10:   level_o <= level_o + LW'(1);
                2'b01:   level_o <= level_o - LW'(1);
                default: ;
            endcase
        end
    end

    assign valid_o = (level_o != '0);
    assign full_o  = (level_o == LW'(DEPTH));
    // Empty FIFO presents zero rather than stale or uninitialised storage.
    assign rdata_o = valid_o ? mem[rd_ptr] : '0;

endmodule

// File: rtl/resampler_axis_out.sv
// AXI-Stream output stage for the resampler: FIFO buffering, overflow drop/flag and tlast framing.
// Optional drop counter enabled by defining RESAMP_AXIS_OUT_DROP_CNT_EN.
module resampler_axis_out
    import dsp_pkg::*;
#(
    parameter  int CH_NUM     = 2,
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = RESAMP_DEPTH_DEFAULT,
    parameter  int CNT_WIDTH  = 16,
    localparam int LW         = level_width(DEPTH)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  en_i,
    input  logic                                  clr_i,
    input  logic [CNT_WIDTH-1:0]                  frame_len_i,
    input  logic                                  tvalid_i,
    input  logic [CH_NUM-1:0][DATA_WIDTH-1:0]     tdata_i,
    output logic                                  m_tvalid_o,
    input  logic                                  m_tready_i,
    output logic [CH_NUM-1:0][DATA_WIDTH-1:0]     m_tdata_o,
    output logic                                  m_tlast_o,
    output logic [LW-1:0]                         level_o,
    output logic                                  overflow_o,
    output logic [CNT_WIDTH-1:0]                  drop_cnt_o
);

    logic                 pop;
    logic                 push;
    logic                 full;
    logic                 drop;
    logic                 last_beat;
    logic [CNT_WIDTH-1:0] beat_cnt;

    assign pop  = m_tvalid_o & m_tready_i & en_i;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push = tvalid_i & en_i & (~full | pop);
    assign drop = tvalid_i & en_i & full & ~pop;

    sync_fifo_fwft #(
        .WIDTH (CH_NUM * DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (tdata_i),
        .rdata_o (m_tdata_o),
        .level_o (level_o),
        .full_o  (full),
        .valid_o (m_tvalid_o)
    );

    // NOTE: single unconditional assignment keeps this combinational block latch-free.
    always_comb begin
        last_beat = (frame_len_i >= CNT_WIDTH'(2)) ? (beat_cnt == frame_len_i - CNT_WIDTH'(1))
                                                   : 1'b1;
    end

    assign m_tlast_o = m_tvalid_o & last_beat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= m_tlast_o ? '0 : beat_cnt + CNT_WIDTH'(1);
        end
    end

    // A drop coinciding with clr_i takes priority so the new loss is never hidden.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
        end else if (en_i) begin
            if (drop)       overflow_o <= 1'b1;
            else if (clr_i) overflow_o <= 1'b0;
        end
    end

`ifdef RESAMP_AXIS_OUT_DROP_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_o <= '0;
        end else if (en_i) begin
            if (drop) begin
                if (clr_i)              drop_cnt_o <= CNT_WIDTH'(1);
                else if (~&drop_cnt_o)  drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
            end else if (clr_i) begin
                drop_cnt_o <= '0;
            end
        end
    end
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_resampler_axis_out.sv
// Directed/random bench for resampler_axis_out against a queue-based reference model.
module tb_resampler_axis_out;

    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          en_i;
    logic          clr_i;
    logic [CW-1:0] frame_len;
    logic          tvalid;
    logic [31:0]   tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [31:0]   m_tdata;
    logic          m_tlast;
    logic [4:0]    level;
    logic          overflow;
    logic [CW-1:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0]   q[$];
    logic [CW-1:0] m_beat;
    logic          m_ovf;
    logic [CW-1:0] m_drops;

    resampler_axis_out #(
        .CH_NUM     (2),
        .DATA_WIDTH (16),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .frame_len_i (frame_len),
        .tvalid_i    (tvalid),
        .tdata_i     (tdata),
        .m_tvalid_o  (m_tvalid),
        .m_tready_i  (m_tready),
        .m_tdata_o   (m_tdata),
        .m_tlast_o   (m_tlast),
        .level_o     (level),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_last();
        logic [CW-1:0] fm1;
        fm1 = frame_len - CW'(1);
        if (q.size() == 0) return 1'b0;
        if (frame_len < CW'(2)) return 1'b1;
        return (m_beat == fm1);
    endfunction

    function automatic logic [CW-1:0] exp_drops_after(input int n);
`ifdef RESAMP_AXIS_OUT_DROP_CNT_EN
        return CW'(n);
`else
        return (n > 0) ? '0 : '0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_beat  = '0;
        m_ovf   = 1'b0;
        m_drops = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic pop, push, drop, full, lastv;
        full = (q.size() == DEPTH);
        pop  = (q.size() != 0) && m_tready && en_i;
        push = tvalid && en_i && (!full || pop);
        drop = tvalid && en_i && full && !pop;
        lastv = exp_last();
        if (pop) begin
            void'(q.pop_front());
            m_beat = lastv ? '0 : m_beat + CW'(1);
        end
        if (push) q.push_back(tdata);
        if (en_i) begin
            if (drop) begin
                m_ovf = 1'b1;
`ifdef RESAMP_AXIS_OUT_DROP_CNT_EN
                if (clr_i) m_drops = CW'(1);
                else if (m_drops != '1) m_drops = m_drops + CW'(1);
`endif
            end else if (clr_i) begin
                m_ovf   = 1'b0;
                m_drops = '0;
            end
        end
    endtask

    task automatic compare_all();
        chk("m_tvalid", 32'(m_tvalid), 32'(q.size() != 0));
        chk("level", 32'(level), 32'(q.size()));
        if (q.size() != 0) chk("m_tdata", m_tdata, q[0]);
        chk("m_tlast", 32'(m_tlast), 32'(exp_last()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    endtask

    // Called at a negedge: apply inputs, step the model, pass the posedge, compare.
    task automatic drive(input logic tv, input logic [31:0] d, input logic rdy,
                         input logic en, input logic clr);
        tvalid   = tv;
        tdata    = d;
        m_tready = rdy;
        en_i     = en;
        clr_i    = clr;
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    initial begin
        rst_ni    = 1'b0;
        en_i      = 1'b1;
        clr_i     = 1'b0;
        frame_len = '0;
        tvalid    = 1'b0;
        tdata     = '0;
        m_tready  = 1'b0;
        model_reset();

        repeat (2) @(negedge clk_i);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        compare_all();

        // Streaming pass-through with ready held high
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 32'(i), 1'b1, 1'b1, 1'b0);
            chk("t1_level_le1", 32'(level <= 5'd1), 32'd1);
        end
        repeat (2) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Overfill with ready low, then drain
        for (int i = 0; i < 20; i++) drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        chk("t2_level_full", 32'(level), 32'd16);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_drop_cnt", 32'(drop_cnt), 32'(exp_drops_after(4)));
        for (int i = 0; i < 17; i++) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("t2_clr_overflow", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop, then frozen by en_i=0
        for (int i = 0; i < 16; i++) drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
            chk("t3_level", 32'(level), 32'd16);
            chk("t3_overflow", 32'(overflow), 32'd0);
        end
        repeat (3) drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        chk("t3_frozen_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 17; i++) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Framing with random backpressure and mid-stream length changes
        frame_len = CW'(4);
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        frame_len = '0;
        for (int i = 0; i < 20; i++)
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        frame_len = CW'(3);
        for (int i = 0; i < 30; i++)
            drive(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        frame_len = CW'(7);
        for (int i = 0; i < 30; i++)
            drive(1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b1, 1'b0);

        // Stall: head beat must hold while ready is low
        drive(1'b1, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-stream at level 7
        frame_len = CW'(4);
        for (int i = 0; i < 7; i++) drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        chk("t6_level7", 32'(level), 32'd7);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_tvalid_async", 32'(m_tvalid), 32'd0);
        chk("t6_level_async", 32'(level), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        compare_all();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Clear coinciding with a drop
        for (int i = 0; i < 17; i++) drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        drive(1'b1, $urandom, 1'b0, 1'b1, 1'b1);
        chk("t7_ovf_wins", 32'(overflow), 32'd1);
        chk("t7_cnt_wins", 32'(drop_cnt), 32'(exp_drops_after(1)));
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("t7_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 17; i++) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
